// File: rtl/cla5_sub_pipe.sv
// Two-stage pipelined 5-bit subtractor (a - b - bin) using a carry-lookahead
// network over a + ~b + ~bin. Optional saturation under CLA5_SUB_SAT_EN.
module cla5_sub_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] a_in,
  input  logic [4:0] b_in,
  input  logic       bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] diff,
  output logic       bout,
  output logic       zero
);

  // Handshake: a side transfers on a rising edge where valid & ready are both
  // high; producers hold data while valid & ~ready, valid never drops untaken.

  logic [4:0] a_q, a_d, b_q, b_d;
  logic       bin_q, bin_d;
  logic       s1_valid_q, s1_valid_d;
  logic [4:0] diff_q, diff_d;
  logic       bout_q, bout_d;
  logic       zero_q, zero_d;
  logic       out_valid_q, out_valid_d;

  logic       adv2;
  logic       in_xfer;

  logic [4:0] nb, g, p, c;
  logic       cin;
  logic [4:0] diff_raw;
  logic [4:0] diff_c;
  logic       bout_c;
  logic       zero_c;

  assign adv2     = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | adv2;
  assign in_xfer  = in_valid & in_ready;

  // Lookahead carries, each expanded to sum-of-products over g/p and cin.
  always_comb begin
    nb  = ~b_q;
    g   = a_q & nb;
    p   = a_q ^ nb;
    cin = ~bin_q;

    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    c[4] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
         | (p[4] & p[3] & p[2] & g[1])
         | (p[4] & p[3] & p[2] & p[1] & g[0])
         | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);

    diff_raw = p ^ {c[3:0], cin};
    bout_c   = ~c[4];
    zero_c   = (diff_raw == 5'd0);
`ifdef CLA5_SUB_SAT_EN
    diff_c   = bout_c ? 5'd0 : diff_raw;
`else
    diff_c   = diff_raw;
`endif
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    bin_d       = bin_q;
    s1_valid_d  = s1_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    if (adv2) begin
      out_valid_d = s1_valid_q;
      s1_valid_d  = 1'b0;
      // Result registers only change when real data moves, so idle outputs stay put.
      if (s1_valid_q) begin
        diff_d = diff_c;
        bout_d = bout_c;
        zero_d = zero_c;
      end
    end

    if (in_xfer) begin
      a_d        = a_in;
      b_d        = b_in;
      bin_d      = bin;
      s1_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= 5'd0;
      b_q         <= 5'd0;
      bin_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      diff_q      <= 5'd0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      bin_q       <= bin_d;
      s1_valid_q  <= s1_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla5_sub_pipe.sv
// Self-checking bench for cla5_sub_pipe: directed edge cases, random streaming,
// backpressure and mid-flight reset against an integer-arithmetic model.
module tb_cla5_sub_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a_in;
  logic [4:0] b_in;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] diff;
  logic       bout;
  logic       zero;

  int n_vec;
  int n_err;

  // Expected results as {bout, zero, diff}, in acceptance order.
  logic [6:0] exp_q[$];

  cla5_sub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] model(input logic [4:0] a, input logic [4:0] b,
                                       input logic bi);
    int d;
    logic [4:0] r;
    logic bo, z;
    d  = int'(a) - int'(b) - int'(bi);
    bo = (d < 0);
    r  = 5'(d & 31);
    z  = (r == 5'd0);
`ifdef CLA5_SUB_SAT_EN
    if (bo) r = 5'd0;
`endif
    return {bo, z, r};
  endfunction

  // Drives one cycle of stimulus from posedge+1, observes at the negedge,
  // updates the scoreboard and returns at the next posedge+1.
  task automatic step(input logic iv, input logic [4:0] a, input logic [4:0] b,
                      input logic bi, input logic ordy,
                      output logic acc, output logic got,
                      output logic [6:0] obs, output logic [6:0] exp,
                      output logic have_exp);
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    bin       = bi;
    out_ready = ordy;
    @(negedge clk);
    got      = out_valid & out_ready;
    acc      = in_valid & in_ready;
    obs      = {bout, zero, diff};
    exp      = 7'd0;
    have_exp = 1'b0;
    if (got && exp_q.size() > 0) begin
      exp      = exp_q.pop_front();
      have_exp = 1'b1;
    end
    if (acc) exp_q.push_back(model(a, b, bi));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = 5'd0;
    b_in      = 5'd0;
    bin       = 1'b0;
    out_ready = 1'b0;
    #2;
    n_vec++;
    if ({out_valid, bout, zero, diff} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000000", {out_valid, bout, zero, diff});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  logic [4:0] dir_a [5] = '{5'd13, 5'd5, 5'd0, 5'd31, 5'd31};
  logic [4:0] dir_b [5] = '{5'd5, 5'd13, 5'd0, 5'd31, 5'd0};
  logic       dir_bi[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_directed();
    logic acc, got, he;
    logic [6:0] obs, exp;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, dir_a[i], dir_b[i], dir_bi[i], 1'b1, acc, got, obs, exp, he);
      n_vec++;
      if (acc !== 1'b1) begin
        n_err++;
        $display("FAIL directed_accept[%0d]: got %b want 1", i, acc);
      end
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, acc, got, obs, exp, he);
      n_vec++;
      if (got !== 1'b0) begin
        n_err++;
        $display("FAIL directed_early[%0d]: out_valid %b want 0", i, got);
      end
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, acc, got, obs, exp, he);
      n_vec++;
      if (got !== 1'b1 || !he || obs !== exp) begin
        n_err++;
        $display("FAIL directed[%0d] %0d-%0d-%0d: got v=%b {bout,zero,diff}=%b want v=1 %b",
                 i, dir_a[i], dir_b[i], dir_bi[i], got, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, got, he;
    logic [6:0] obs, exp;
    int outs;
    outs = 0;
    for (int i = 0; i < 36; i++) begin
      if (i < 32)
        step(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'b1, acc, got, obs, exp, he);
      else
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, acc, got, obs, exp, he);
      if (i < 32) begin
        n_vec++;
        if (acc !== 1'b1) begin
          n_err++;
          $display("FAIL stream_accept[%0d]: got %b want 1", i, acc);
        end
      end
      if (got) begin
        outs++;
        n_vec++;
        if (!he || obs !== exp) begin
          n_err++;
          $display("FAIL stream_data[%0d]: got %b want %b (expected present %b)", i, obs, exp, he);
        end
      end
      if (i == 33) begin
        n_vec++;
        if (outs != 32) begin
          n_err++;
          $display("FAIL stream_throughput: got %0d results want 32", outs);
        end
      end
    end
    n_vec++;
    if (outs != 32) begin
      n_err++;
      $display("FAIL stream_total: got %0d results want 32", outs);
    end
  endtask

  task automatic test_backpressure();
    logic acc, got, he;
    logic [6:0] obs, exp;
    logic [4:0] pa[3], pb[3];
    logic       pbi[3];
    logic [7:0] snap;
    logic       acc_exp[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int idx, outs;
    for (int i = 0; i < 3; i++) begin
      pa[i]  = 5'($urandom_range(0, 31));
      pb[i]  = 5'($urandom_range(0, 31));
      pbi[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, pa[idx], pb[idx], pbi[idx], 1'b0, acc, got, obs, exp, he);
      n_vec++;
      if (acc !== acc_exp[k]) begin
        n_err++;
        $display("FAIL bp_accept[%0d]: got %b want %b", k, acc, acc_exp[k]);
      end
      if (acc && idx < 2) idx++;
    end
    snap = {out_valid, bout, zero, diff};
    step(1'b1, pa[idx], pb[idx], pbi[idx], 1'b0, acc, got, obs, exp, he);
    n_vec++;
    if ({out_valid, bout, zero, diff} !== snap || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stable: got %b want %b with out_valid 1", {out_valid, bout, zero, diff}, snap);
    end
    outs = 0;
    for (int k = 0; k < 8; k++) begin
      step(idx < 3, pa[idx < 3 ? idx : 0], pb[idx < 3 ? idx : 0],
           pbi[idx < 3 ? idx : 0], 1'b1, acc, got, obs, exp, he);
      if (acc) idx++;
      if (got) begin
        outs++;
        n_vec++;
        if (!he || obs !== exp) begin
          n_err++;
          $display("FAIL bp_drain[%0d]: got %b want %b (expected present %b)", k, obs, exp, he);
        end
      end
    end
    n_vec++;
    if (outs != 3 || idx != 3) begin
      n_err++;
      $display("FAIL bp_count: got %0d results %0d accepts want 3 3", outs, idx);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, got, he;
    logic [6:0] obs, exp;
    int accs;
    accs = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'b0, acc, got, obs, exp, he);
      if (acc) accs++;
    end
    n_vec++;
    if (accs != 2 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_fill: got %0d accepts out_valid %b want 2 1", accs, out_valid);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, bout, zero, diff} !== 8'd0) begin
      n_err++;
      $display("FAIL rst_async: got %b want 00000000", {out_valid, bout, zero, diff});
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, acc, got, obs, exp, he);
      n_vec++;
      if (got !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stale[%0d]: out_valid %b want 0", k, got);
      end
    end
    step(1'b1, 5'd20, 5'd7, 1'b1, 1'b1, acc, got, obs, exp, he);
    for (int k = 0; k < 2; k++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, acc, got, obs, exp, he);
    n_vec++;
    if (got !== 1'b1 || !he || obs !== exp) begin
      n_err++;
      $display("FAIL rst_recover: got v=%b %b want v=1 %b", got, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d pending results want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
